// File: rtl/decoder_stage_controller_multi_round_pkg.sv
// rtl/decoder_stage_controller_multi_round_pkg.sv - stage codes shared by the controller, the PUs and the decoder array
package decoder_stage_controller_multi_round_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE   = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_LOAD   = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW   = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE  = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SYNC   = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT = 3'd5;

  // Controller state codes are the stage codes, so the stage output is the state register itself
  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE   = STAGE_IDLE,
    ST_LOAD   = STAGE_LOAD,
    ST_GROW   = STAGE_GROW,
    ST_MERGE  = STAGE_MERGE,
    ST_SYNC   = STAGE_SYNC,
    ST_RESULT = STAGE_RESULT
  } state_t;

endpackage

// File: rtl/decoder_stage_controller_multi_round_if.sv
// rtl/decoder_stage_controller_multi_round_if.sv - start/ack handshake, array status and stage/result bundle
// master = stage controller, slave = host/front-end and decoder array side
interface decoder_stage_controller_multi_round_if #(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int CYCLE_COUNTER_WIDTH     = 16
);
  import decoder_stage_controller_multi_round_pkg::*;

  logic                               start;
  logic                               busy;
  logic                               has_message_flying;
  logic                               has_odd_clusters;
  logic [STAGE_WIDTH-1:0]             stage;
  logic                               result_valid;
  logic                               result_ack;
  logic                               timeout;
  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
  logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter;
  logic                               watchdog_tripped;

  modport master (
    input  start, has_message_flying, has_odd_clusters, result_ack,
    output busy, stage, result_valid, timeout, iteration_counter, cycle_counter, watchdog_tripped
  );

  modport slave (
    output start, has_message_flying, has_odd_clusters, result_ack,
    input  busy, stage, result_valid, timeout, iteration_counter, cycle_counter, watchdog_tripped
  );

endinterface

// File: rtl/decoder_stage_controller_multi_round_stage_settle_counter.sv
// rtl/decoder_stage_controller_multi_round_stage_settle_counter.sv - quiet-window counter for MERGE/SYNC exit
// o_done is combinational: it marks the cycle whose closing edge completes SETTLE_CYCLES quiet cycles
module stage_settle_counter #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_clear,
  input  logic i_flying,
  output logic o_done
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_restart;

  assign o_done    = i_active && !i_flying && (r_count == COUNT_LAST);
  assign w_restart = i_clear || !i_active || i_flying || o_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (w_restart) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_stage_controller_multi_round.sv
// rtl/decoder_stage_controller_multi_round.sv - sequences LOAD/GROW/MERGE/SYNC rounds until no odd clusters remain
// Optional per-visit MERGE/SYNC dwell watchdog: STAGE_CONTROLLER_WATCHDOG_EN
module decoder_stage_controller_multi_round
  import decoder_stage_controller_multi_round_pkg::*;
#(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 16,
  parameter int LOAD_CYCLES             = 2,
  parameter int SETTLE_CYCLES           = 3,
  parameter int CYCLE_COUNTER_WIDTH     = 16,
  parameter int WATCHDOG_CYCLES         = 1024
) (
  input logic                                   i_clk,
  input logic                                   i_reset,
  decoder_stage_controller_multi_round_if.master bus
);

  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [ITERATION_COUNTER_WIDTH-1:0] MAX_ITER = ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS);

  state_t                             r_state;
  state_t                             w_next_state;
  logic [LW-1:0]                      r_load_count;
  logic [ITERATION_COUNTER_WIDTH-1:0] r_iteration;
  logic [CYCLE_COUNTER_WIDTH-1:0]     r_cycle;
  logic                               r_timeout;
  logic                               r_watchdog;

  logic w_in_settle;
  logic w_settle_done;
  logic w_watchdog_hit;
  logic w_state_change;
  logic w_counting;
  logic w_clear;
  logic w_set_timeout;
  logic w_set_watchdog;
  logic w_iter_inc;

  assign w_in_settle    = (r_state == ST_MERGE) || (r_state == ST_SYNC);
  assign w_state_change = (r_state != w_next_state);
  assign w_counting     = (r_state == ST_LOAD) || (r_state == ST_GROW) || w_in_settle;

  stage_settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_active (w_in_settle),
    .i_clear  (w_state_change),
    .i_flying (bus.has_message_flying),
    .o_done   (w_settle_done)
  );

`ifdef STAGE_CONTROLLER_WATCHDOG_EN
  localparam int DW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(WATCHDOG_CYCLES - 1);

  logic [DW-1:0] r_dwell;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dwell <= '0;
    end else if (!w_in_settle || w_state_change) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  assign w_watchdog_hit = w_in_settle && (r_dwell == DWELL_LAST);
`else
  // No dwell counter in this build; the comparison is constant false and only keeps the parameter referenced
  assign w_watchdog_hit = (WATCHDOG_CYCLES < 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_clear        = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_watchdog = 1'b0;
    w_iter_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_LOAD;
          w_clear      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (r_load_count == LOAD_LAST) begin
          w_next_state = ST_SYNC;
        end
      end
      ST_GROW: begin
        w_next_state = ST_MERGE;
      end
      ST_MERGE: begin
        if (w_settle_done) begin
          w_next_state = ST_SYNC;
        end else if (w_watchdog_hit) begin
          w_next_state   = ST_RESULT;
          w_set_watchdog = 1'b1;
        end
      end
      ST_SYNC: begin
        // A quiet window completing on the same edge as the watchdog wins: the SYNC decision is valid
        if (w_settle_done) begin
          if (!bus.has_odd_clusters) begin
            w_next_state = ST_RESULT;
          end else if (r_iteration == MAX_ITER) begin
            w_next_state  = ST_RESULT;
            w_set_timeout = 1'b1;
          end else begin
            w_next_state = ST_GROW;
            w_iter_inc   = 1'b1;
          end
        end else if (w_watchdog_hit) begin
          w_next_state   = ST_RESULT;
          w_set_watchdog = 1'b1;
        end
      end
      ST_RESULT: begin
        if (bus.result_ack) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_load_count <= '0;
    end else if ((r_state == ST_LOAD) && (w_next_state == ST_LOAD)) begin
      r_load_count <= r_load_count + LW'(1);
    end else begin
      r_load_count <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_iteration <= '0;
      r_cycle     <= '0;
      r_timeout   <= 1'b0;
      r_watchdog  <= 1'b0;
    end else if (w_clear) begin
      r_iteration <= '0;
      r_cycle     <= '0;
      r_timeout   <= 1'b0;
      r_watchdog  <= 1'b0;
    end else begin
      if (w_iter_inc) begin
        r_iteration <= r_iteration + ITERATION_COUNTER_WIDTH'(1);
      end
      if (w_counting && (r_cycle != '1)) begin
        r_cycle <= r_cycle + CYCLE_COUNTER_WIDTH'(1);
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_set_watchdog) begin
        r_watchdog <= 1'b1;
      end
    end
  end

  assign bus.stage             = r_state;
  assign bus.busy              = (r_state != ST_IDLE);
  assign bus.result_valid      = (r_state == ST_RESULT);
  assign bus.iteration_counter = r_iteration;
  assign bus.cycle_counter     = r_cycle;
  assign bus.timeout           = r_timeout;
  assign bus.watchdog_tripped  = r_watchdog;

endmodule

// File: tb/tb_decoder_stage_controller_multi_round.sv
// tb/tb_decoder_stage_controller_multi_round.sv - directed bench for the multi-round stage controller
module tb_decoder_stage_controller_multi_round;
  import decoder_stage_controller_multi_round_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [STAGE_WIDTH-1:0] stage_log[$];

  decoder_stage_controller_multi_round_if #(
    .ITERATION_COUNTER_WIDTH (8),
    .CYCLE_COUNTER_WIDTH     (16)
  ) bus ();

  decoder_stage_controller_multi_round #(
    .ITERATION_COUNTER_WIDTH (8),
    .MAX_ITERATIONS          (2),
    .LOAD_CYCLES             (2),
    .SETTLE_CYCLES           (3),
    .CYCLE_COUNTER_WIDTH     (16),
    .WATCHDOG_CYCLES         (8)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack;
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
  endtask

  // odd_syncs: number of SYNC visits reporting odd clusters; fly_mode 1 = flying for first 5 MERGE cycles, 2 = glitch on 3rd
  task automatic drive_decode(input int odd_syncs, input int fly_mode, output int merge_dwell, output int edges);
    logic [STAGE_WIDTH-1:0] prev;
    int syncs;
    int merges;
    int m;
    stage_log.delete();
    syncs = 0; merges = 0; m = 0; merge_dwell = 0; edges = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    prev = STAGE_IDLE;
    while (bus.result_valid !== 1'b1 && edges < 200) begin
      if (bus.stage !== prev) begin
        stage_log.push_back(bus.stage);
        if (bus.stage == STAGE_SYNC) syncs++;
        if (bus.stage == STAGE_MERGE) begin merges++; m = 0; end
      end
      if (bus.stage == STAGE_MERGE) m++;
      if (merges == 1 && bus.stage == STAGE_MERGE) merge_dwell = m;
      bus.has_odd_clusters   = (syncs <= odd_syncs);
      bus.has_message_flying = (bus.stage == STAGE_MERGE) && (merges == 1) &&
                               ((fly_mode == 1 && m <= 5) || (fly_mode == 2 && m == 3));
      prev = bus.stage;
      tick();
      edges++;
    end
    bus.has_message_flying = 1'b0;
    bus.has_odd_clusters   = 1'b0;
    if (bus.result_valid === 1'b1) stage_log.push_back(bus.stage);
  endtask

  task automatic test_reset;
    #3;
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL reset_stage: got %0d expected %0d", bus.stage, STAGE_IDLE); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_result_valid: got %b expected 0", bus.result_valid); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
    n_vec++; if (bus.iteration_counter !== 8'd0) begin n_err++; $display("FAIL reset_iter: got %0d expected 0", bus.iteration_counter); end
    n_vec++; if (bus.cycle_counter !== 16'd0) begin n_err++; $display("FAIL reset_cycle: got %0d expected 0", bus.cycle_counter); end
    n_vec++; if (bus.watchdog_tripped !== 1'b0) begin n_err++; $display("FAIL reset_watchdog: got %b expected 0", bus.watchdog_tripped); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL idle_after_reset: got %0d expected %0d", bus.stage, STAGE_IDLE); end
  endtask

  task automatic test_single;
    int d;
    int e;
    drive_decode(0, 0, d, e);
    n_vec++; if (e != 5) begin n_err++; $display("FAIL single_latency: got %0d expected 5", e); end
    n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.result_valid); end
    n_vec++; if (bus.iteration_counter !== 8'd0) begin n_err++; $display("FAIL single_iter: got %0d expected 0", bus.iteration_counter); end
    n_vec++; if (bus.cycle_counter !== 16'd5) begin n_err++; $display("FAIL single_cycle: got %0d expected 5", bus.cycle_counter); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL single_timeout: got %b expected 0", bus.timeout); end
    do_ack();
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL single_ack_idle: got %0d expected %0d", bus.stage, STAGE_IDLE); end
  endtask

  task automatic test_timeout;
    int d;
    int e;
    drive_decode(99, 0, d, e);
    n_vec++; if (e != 19) begin n_err++; $display("FAIL timeout_latency: got %0d expected 19", e); end
    n_vec++; if (bus.timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b expected 1", bus.timeout); end
    n_vec++; if (bus.iteration_counter !== 8'd2) begin n_err++; $display("FAIL timeout_iter: got %0d expected 2", bus.iteration_counter); end
    n_vec++; if (bus.cycle_counter !== 16'd19) begin n_err++; $display("FAIL timeout_cycle: got %0d expected 19", bus.cycle_counter); end
    do_ack();
  endtask

  task automatic test_one_round;
    int d;
    int e;
    logic [STAGE_WIDTH-1:0] exp_seq [6];
    exp_seq = '{STAGE_LOAD, STAGE_SYNC, STAGE_GROW, STAGE_MERGE, STAGE_SYNC, STAGE_RESULT};
    drive_decode(1, 0, d, e);
    n_vec++; if (stage_log.size() != 6) begin n_err++; $display("FAIL round_seq_len: got %0d expected 6", stage_log.size()); end
    for (int i = 0; i < 6 && i < stage_log.size(); i++) begin
      n_vec++;
      if (stage_log[i] !== exp_seq[i]) begin n_err++; $display("FAIL round_seq_%0d: got %0d expected %0d", i, stage_log[i], exp_seq[i]); end
    end
    n_vec++; if (bus.iteration_counter !== 8'd1) begin n_err++; $display("FAIL round_iter: got %0d expected 1", bus.iteration_counter); end
    n_vec++; if (bus.cycle_counter !== 16'd12) begin n_err++; $display("FAIL round_cycle: got %0d expected 12", bus.cycle_counter); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL round_timeout_cleared: got %b expected 0", bus.timeout); end
    do_ack();
  endtask

  task automatic test_merge_flying;
    int d;
    int e;
    drive_decode(1, 1, d, e);
    n_vec++; if (d != 8) begin n_err++; $display("FAIL merge_hold_dwell: got %0d expected 8", d); end
    n_vec++; if (bus.cycle_counter !== 16'd17) begin n_err++; $display("FAIL merge_hold_cycle: got %0d expected 17", bus.cycle_counter); end
    do_ack();
    drive_decode(1, 2, d, e);
    n_vec++; if (d != 6) begin n_err++; $display("FAIL merge_glitch_dwell: got %0d expected 6", d); end
    n_vec++; if (bus.cycle_counter !== 16'd15) begin n_err++; $display("FAIL merge_glitch_cycle: got %0d expected 15", bus.cycle_counter); end
    do_ack();
  endtask

  task automatic test_result_hold;
    int d;
    int e;
    drive_decode(1, 0, d, e);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      tick();
      n_vec++;
      if (bus.result_valid !== 1'b1 || bus.stage !== STAGE_RESULT || bus.iteration_counter !== 8'd1 ||
          bus.cycle_counter !== 16'd12 || bus.timeout !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: got stage=%0d valid=%b iter=%0d cycle=%0d timeout=%b expected stage=5 valid=1 iter=1 cycle=12 timeout=0",
                 i, bus.stage, bus.result_valid, bus.iteration_counter, bus.cycle_counter, bus.timeout);
      end
    end
    bus.start      = 1'b1;
    bus.result_ack = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.result_ack = 1'b0;
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL hold_ack_idle: got %0d expected %0d", bus.stage, STAGE_IDLE); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL hold_ack_valid: got %b expected 0", bus.result_valid); end
    tick();
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL hold_start_dropped: got %0d expected %0d", bus.stage, STAGE_IDLE); end
  endtask

  task automatic test_reset_mid_merge;
    int n;
    bus.has_odd_clusters = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.stage !== STAGE_MERGE && n < 50) begin tick(); n++; end
    n_vec++; if (bus.stage !== STAGE_MERGE) begin n_err++; $display("FAIL abort_reach_merge: got %0d expected %0d", bus.stage, STAGE_MERGE); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL abort_stage: got %0d expected %0d", bus.stage, STAGE_IDLE); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.iteration_counter !== 8'd0) begin n_err++; $display("FAIL abort_iter: got %0d expected 0", bus.iteration_counter); end
    n_vec++; if (bus.cycle_counter !== 16'd0) begin n_err++; $display("FAIL abort_cycle: got %0d expected 0", bus.cycle_counter); end
    bus.has_odd_clusters = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.result_valid !== 1'b0 || bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL abort_no_result: got stage=%0d valid=%b expected stage=0 valid=0", bus.stage, bus.result_valid); end
  endtask

  task automatic test_watchdog;
    int n;
    int m;
    bus.has_odd_clusters = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.stage !== STAGE_MERGE && n < 50) begin tick(); n++; end
    m = 0;
    while (bus.stage === STAGE_MERGE && m < 50) begin
      bus.has_message_flying = 1'b1;
      m++;
      tick();
    end
    bus.has_message_flying = 1'b0;
    bus.has_odd_clusters   = 1'b0;
`ifdef STAGE_CONTROLLER_WATCHDOG_EN
    n_vec++; if (m != 8) begin n_err++; $display("FAIL wd_merge_dwell: got %0d expected 8", m); end
    n_vec++; if (bus.stage !== STAGE_RESULT) begin n_err++; $display("FAIL wd_stage: got %0d expected %0d", bus.stage, STAGE_RESULT); end
    n_vec++; if (bus.watchdog_tripped !== 1'b1) begin n_err++; $display("FAIL wd_tripped: got %b expected 1", bus.watchdog_tripped); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL wd_timeout: got %b expected 0", bus.timeout); end
    do_ack();
`else
    n_vec++; if (m != 50 || bus.stage !== STAGE_MERGE) begin n_err++; $display("FAIL nowd_stuck_merge: got dwell=%0d stage=%0d expected dwell=50 stage=%0d", m, bus.stage, STAGE_MERGE); end
    n_vec++; if (bus.watchdog_tripped !== 1'b0) begin n_err++; $display("FAIL nowd_tripped: got %b expected 0", bus.watchdog_tripped); end
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif
    n_vec++; if (bus.stage !== STAGE_IDLE) begin n_err++; $display("FAIL wd_back_idle: got %0d expected %0d", bus.stage, STAGE_IDLE); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start              = 1'b0;
    bus.has_message_flying = 1'b0;
    bus.has_odd_clusters   = 1'b0;
    bus.result_ack         = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_one_round();
    test_merge_flying();
    test_result_hold();
    test_reset_mid_merge();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
